imm_gen: RTL and testbench

//  Immediate generator for the RV32I multicycle core. It decodes a 32-bit

---
 rtl/imm_gen_pkg.sv | 30 +++
 rtl/imm_gen_decode.sv | 37 +++
 rtl/imm_gen.sv | 65 ++++++
 tb/tb_imm_gen.sv | 136 +++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared RV32I opcode constants and immediate-format encodings.
// Used by the immediate generator and the control FSM.
package imm_gen_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

endpackage

// File: rtl/imm_gen_decode.sv
// Opcode/funct3 decode into immediate format, illegal flag and shift-amount select.
// Purely combinational, no flow control.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output fmt_t       fmt,
    output logic       illegal,
    output logic       shamt_sel
);

    always_comb begin
        fmt       = FMT_NONE;
        illegal   = 1'b0;
        shamt_sel = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                fmt       = FMT_I;
                shamt_sel = SHAMT_ZEXT && (funct3 == F3_SLLI || funct3 == F3_SRXI);
            end
            OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:           fmt = FMT_S;
            OPC_BRANCH:          fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
            OPC_JAL:             fmt = FMT_J;
            OPC_OP:              fmt = FMT_R;
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator: combinational imm/fmt/illegal plus a registered copy.
// Latency 0 cycles for imm, 1 cycle for imm_q; no backpressure, accepts every cycle.
module imm_gen
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm_q,
    output logic [2:0]      fmt_q,
    output logic            valid_q
);

    fmt_t fmt_dec;
    logic shamt_sel;

    imm_gen_decode #(
        .SHAMT_ZEXT (SHAMT_ZEXT)
    ) u_decode (
        .opcode    (inst[6:0]),
        .funct3    (inst[14:12]),
        .fmt       (fmt_dec),
        .illegal   (illegal),
        .shamt_sel (shamt_sel)
    );

    assign fmt = fmt_dec;

    always_comb begin
        imm = '0;
        case (fmt_dec)
            FMT_I: begin
                // Shift immediates carry funct7 in [31:25]; expose only the shamt.
                if (shamt_sel)
                    imm = {27'b0, inst[24:20]};
                else
                    imm = {{20{inst[31]}}, inst[31:20]};
            end
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q   <= '0;
            fmt_q   <= FMT_NONE;
            valid_q <= 1'b0;
        end else begin
            imm_q   <= imm;
            fmt_q   <= fmt;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed bench for imm_gen: combinational decode vectors and the registered path.
module tb_imm_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic [31:0] imm, imm_q;
    logic [2:0]  fmt, fmt_q;
    logic        illegal, valid_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } comb_exp_t;

    typedef struct {
        string       tag;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        vld;
    } reg_exp_t;

    comb_exp_t comb_sb[$];
    reg_exp_t  reg_sb[$];

    imm_gen dut (
        .clk     (clk),
        .rst     (rst),
        .inst    (inst),
        .imm     (imm),
        .fmt     (fmt),
        .illegal (illegal),
        .imm_q   (imm_q),
        .fmt_q   (fmt_q),
        .valid_q (valid_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive an instruction, queue its expectation, then pop and compare once settled.
    task automatic comb_step(input string tag, input logic [31:0] i,
                             input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
        comb_exp_t e;
        inst = i;
        comb_sb.push_back('{tag, e_imm, e_fmt, e_ill});
        #1;
        if (comb_sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = comb_sb.pop_front();
            check({e.tag, "_imm"}, imm, e.imm);
            check({e.tag, "_fmt"}, {29'd0, fmt}, {29'd0, e.fmt});
            check({e.tag, "_ill"}, {31'd0, illegal}, {31'd0, e.ill});
        end
    endtask

    // Queue the expected register contents for the coming edge, then check after it.
    task automatic reg_step(input string tag, input logic [31:0] e_imm,
                            input logic [2:0] e_fmt, input logic e_vld);
        reg_exp_t e;
        reg_sb.push_back('{tag, e_imm, e_fmt, e_vld});
        @(posedge clk);
        #1;
        if (reg_sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = reg_sb.pop_front();
            check({e.tag, "_imm_q"}, imm_q, e.imm);
            check({e.tag, "_fmt_q"}, {29'd0, fmt_q}, {29'd0, e.fmt});
            check({e.tag, "_valid_q"}, {31'd0, valid_q}, {31'd0, e.vld});
        end
    endtask

    initial begin
        // Two reset edges with a non-zero immediate on inst.
        rst  = 1'b1;
        inst = 32'h014AAA93;
        reg_step("rst_edge1", 32'h0, 3'd7, 1'b0);
        reg_step("rst_edge2", 32'h0, 3'd7, 1'b0);

        // Combinational outputs must not depend on rst.
        comb_step("addi",      32'h014AAA93, 32'd20,        3'd1, 1'b0);
        comb_step("lw",        32'h014AAA83, 32'd20,        3'd1, 1'b0);
        comb_step("sw",        32'h015AAA23, 32'd20,        3'd2, 1'b0);
        comb_step("beq",       32'h01555A63, 32'd20,        3'd3, 1'b0);
        comb_step("addi_m1",   32'hFFF00093, 32'hFFFFFFFF,  3'd1, 1'b0);
        comb_step("beq_m4",    32'hFE000EE3, 32'hFFFFFFFC,  3'd3, 1'b0);
        comb_step("jal_m2",    32'hFFFFF06F, 32'hFFFFFFFE,  3'd5, 1'b0);
        comb_step("lui",       32'h12345037, 32'h12345000,  3'd4, 1'b0);
        comb_step("auipc",     32'hFFFFF017, 32'hFFFFF000,  3'd4, 1'b0);
        comb_step("srai",      32'h4030D093, 32'd3,         3'd1, 1'b0);
        comb_step("slli",      32'h01F09093, 32'd31,        3'd1, 1'b0);
        comb_step("jalr_m8",   32'hFF8080E7, 32'hFFFFFFF8,  3'd1, 1'b0);
        comb_step("sw_m1",     32'hFE000FA3, 32'hFFFFFFFF,  3'd2, 1'b0);
        comb_step("jal_max",   32'h7FFFF06F, 32'h000FFFFE,  3'd5, 1'b0);
        comb_step("add_r",     32'hFFFFFFB3, 32'h0,         3'd0, 1'b0);
        comb_step("opc_7f",    32'hFFFFFFFF, 32'h0,         3'd7, 1'b1);
        comb_step("opc_00",    32'h00000000, 32'h0,         3'd7, 1'b1);

        // Release reset; addi presented before the edge appears on imm_q after it.
        inst = 32'h014AAA93;
        rst  = 1'b0;
        reg_step("reg_addi", 32'd20, 3'd1, 1'b1);
        inst = 32'h015AAA23;
        reg_step("reg_sw", 32'd20, 3'd2, 1'b1);
        inst = 32'hFFFFF06F;
        reg_step("reg_jal", 32'hFFFFFFFE, 3'd5, 1'b1);

        // Mid-stream reset clears the registers; the combinational path keeps decoding.
        rst = 1'b1;
        reg_step("reg_rst_mid", 32'h0, 3'd7, 1'b0);
        comb_step("jal_in_rst", 32'hFFFFF06F, 32'hFFFFFFFE, 3'd5, 1'b0);

        inst = 32'h7F;
        rst  = 1'b0;
        reg_step("reg_illegal", 32'h0, 3'd7, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
